// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared funct/control encodings, state enum and default latencies
package muldiv_pkg;

    localparam logic [5:0] FUNCT_MFHI = 6'b010000;
    localparam logic [5:0] FUNCT_MFLO = 6'b010010;
    localparam logic [5:0] FUNCT_MULT = 6'b011000;
    localparam logic [5:0] FUNCT_DIV  = 6'b011010;

    localparam logic [3:0] MD_IDLE  = 4'b0000;
    localparam logic [3:0] MD_MULT  = 4'b1100;
    localparam logic [3:0] MD_DIV   = 4'b1101;
    localparam logic [3:0] MD_RD_HI = 4'b1000;
    localparam logic [3:0] MD_RD_LO = 4'b1001;

    localparam int MUL_LAT_DEF = 2;
    localparam int DIV_LAT_DEF = 33;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_MF   = 2'd3
    } state_t;

endpackage

// File: rtl/muldiv_seq.sv
// rtl/muldiv_seq.sv - in-order issue sequencer for the iterative multiply/divide unit
module muldiv_seq
    import muldiv_pkg::*;
#(
    parameter int MUL_LAT = MUL_LAT_DEF,
    parameter int DIV_LAT = DIV_LAT_DEF
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [5:0]  req_funct_i,
    input  logic [31:0] req_rs_i,
    input  logic [31:0] req_rt_i,
    output logic        resp_valid_o,
    output logic [31:0] resp_data_o,
    output logic [3:0]  md_ctl_o,
    output logic [31:0] md_op1_o,
    output logic [31:0] md_op2_o,
    input  logic [31:0] md_res_i,
    input  logic        md_stall_i
);

    localparam int LAT_MAX = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int CNT_W   = $clog2(LAT_MAX + 1);
    localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(MUL_LAT - 1);
    localparam logic [CNT_W-1:0] DIV_CNT = CNT_W'(DIV_LAT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    // A latency of one needs no busy state: HI/LO is readable the very next cycle.
    localparam logic MUL_WAIT = (MUL_LAT > 1);
    localparam logic DIV_WAIT = (DIV_LAT > 1);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             mf_hi, mf_hi_nxt;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state        <= ST_IDLE;
            cnt          <= '0;
            mf_hi        <= 1'b0;
            resp_valid_o <= 1'b0;
            resp_data_o  <= '0;
        end else begin
            state        <= state_nxt;
            cnt          <= cnt_nxt;
            mf_hi        <= mf_hi_nxt;
            resp_valid_o <= (state == ST_MF);
            if (state == ST_MF) begin
                resp_data_o <= md_res_i;
            end
        end
    end

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        mf_hi_nxt   = mf_hi;
        req_ready_o = 1'b0;
        md_ctl_o    = MD_IDLE;
        md_op1_o    = '0;
        md_op2_o    = '0;
        case (state)
            ST_IDLE: begin
                req_ready_o = 1'b1;
                if (req_valid_i) begin
                    case (req_funct_i)
                        FUNCT_MULT: begin
                            md_ctl_o = MD_MULT;
                            md_op1_o = req_rs_i;
                            md_op2_o = req_rt_i;
                            if (MUL_WAIT) begin
                                state_nxt = ST_MUL;
                                cnt_nxt   = MUL_CNT;
                            end
                        end
                        FUNCT_DIV: begin
                            md_ctl_o = MD_DIV;
                            md_op1_o = req_rs_i;
                            md_op2_o = req_rt_i;
                            if (DIV_WAIT) begin
                                state_nxt = ST_DIV;
                                cnt_nxt   = DIV_CNT;
                            end
                        end
                        FUNCT_MFHI: begin
                            state_nxt = ST_MF;
                            mf_hi_nxt = 1'b1;
                        end
                        FUNCT_MFLO: begin
                            state_nxt = ST_MF;
                            mf_hi_nxt = 1'b0;
                        end
                        default: ;
                    endcase
                end
            end
            ST_MUL: begin
                if (cnt != '0) begin
                    cnt_nxt = cnt - CNT_ONE;
                end
                if (cnt <= CNT_ONE) begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_DIV: begin
                // Counter parks at zero while the unit still reports a stall.
                if (cnt != '0) begin
                    cnt_nxt = cnt - CNT_ONE;
                end
                if (cnt <= CNT_ONE && !md_stall_i) begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_MF: begin
                md_ctl_o  = mf_hi ? MD_RD_HI : MD_RD_LO;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_muldiv_seq.sv
// tb/tb_muldiv_seq.sv - directed self-checking bench for muldiv_seq with a behavioural unit model
module tb_muldiv_seq;
    import muldiv_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        req_valid_i = 1'b0;
    logic        req_ready_o;
    logic [5:0]  req_funct_i = '0;
    logic [31:0] req_rs_i = '0;
    logic [31:0] req_rt_i = '0;
    logic        resp_valid_o;
    logic [31:0] resp_data_o;
    logic [3:0]  md_ctl_o;
    logic [31:0] md_op1_o;
    logic [31:0] md_op2_o;
    logic [31:0] md_res_i;
    logic        md_stall_i = 1'b0;

    int n_cmp = 0;
    int n_err = 0;

    muldiv_seq #(.MUL_LAT(2), .DIV_LAT(33)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_funct_i(req_funct_i), .req_rs_i(req_rs_i), .req_rt_i(req_rt_i),
        .resp_valid_o(resp_valid_o), .resp_data_o(resp_data_o),
        .md_ctl_o(md_ctl_o), .md_op1_o(md_op1_o), .md_op2_o(md_op2_o),
        .md_res_i(md_res_i), .md_stall_i(md_stall_i)
    );

    always #5 clk_i = ~clk_i;

    // Unit model: computes on the start code, returns HI/LO on the read codes.
    logic [31:0] u_hi, u_lo;
    logic signed [63:0] u_prod;
    assign u_prod = $signed({{32{md_op1_o[31]}}, md_op1_o}) * $signed({{32{md_op2_o[31]}}, md_op2_o});
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            u_hi <= '0;
            u_lo <= '0;
        end else if (md_ctl_o == MD_MULT) begin
            u_hi <= u_prod[63:32];
            u_lo <= u_prod[31:0];
        end else if (md_ctl_o == MD_DIV && md_op2_o != '0) begin
            u_lo <= $signed(md_op1_o) / $signed(md_op2_o);
            u_hi <= $signed(md_op1_o) % $signed(md_op2_o);
        end
    end
    assign md_res_i = (md_ctl_o == MD_RD_HI) ? u_hi : (md_ctl_o == MD_RD_LO) ? u_lo : 32'h0;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Holds a request until accepted; reports wait cycles and what the DUT drove.
    task automatic issue(input logic [5:0] f, input logic [31:0] rs, input logic [31:0] rt,
                         output int waited, output logic [3:0] ctl_first, output logic [3:0] ctl_acc,
                         output logic [31:0] op1_acc, output logic [31:0] op2_acc);
        req_valid_i = 1'b1;
        req_funct_i = f;
        req_rs_i    = rs;
        req_rt_i    = rt;
        waited      = 0;
        #1;
        ctl_first = md_ctl_o;
        while (!req_ready_o && waited < 100) begin
            tick();
            #1;
            waited++;
        end
        ctl_acc = md_ctl_o;
        op1_acc = md_op1_o;
        op2_acc = md_op2_o;
        tick();
        req_valid_i = 1'b0;
        req_funct_i = '0;
        req_rs_i    = '0;
        req_rt_i    = '0;
    endtask

    task automatic wait_resp(output int lat, output logic [3:0] ctl_rd);
        lat    = 1;
        ctl_rd = md_ctl_o;
        while (!resp_valid_o && lat < 100) begin
            tick();
            lat++;
        end
    endtask

    task automatic test_reset();
        #1;
        n_cmp++; if (req_ready_o !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b expected 1", req_ready_o); end
        n_cmp++; if (md_ctl_o !== MD_IDLE) begin n_err++; $display("FAIL reset_ctl: got %b expected 0000", md_ctl_o); end
        n_cmp++; if (resp_valid_o !== 1'b0) begin n_err++; $display("FAIL reset_resp_valid: got %b expected 0", resp_valid_o); end
        n_cmp++; if (resp_data_o !== 32'h0) begin n_err++; $display("FAIL reset_resp_data: got %h expected 0", resp_data_o); end
        n_cmp++; if ({md_op1_o, md_op2_o} !== 64'h0) begin n_err++; $display("FAIL reset_ops: got %h expected 0", {md_op1_o, md_op2_o}); end
        tick();
        tick();
        rst_ni = 1'b1;
        tick();
        tick();
        n_cmp++; if (req_ready_o !== 1'b1 || md_ctl_o !== MD_IDLE || resp_valid_o !== 1'b0) begin
            n_err++; $display("FAIL idle_after_reset: got ready=%b ctl=%b rv=%b expected 1/0000/0", req_ready_o, md_ctl_o, resp_valid_o);
        end
    endtask

    task automatic test_mult();
        int w, lat;
        logic [3:0] cf, ca, crd;
        logic [31:0] o1, o2;
        issue(FUNCT_MULT, 32'd7, 32'hFFFF_FFFD, w, cf, ca, o1, o2);
        n_cmp++; if (w !== 0) begin n_err++; $display("FAIL mult_wait: got %0d expected 0", w); end
        n_cmp++; if (ca !== MD_MULT) begin n_err++; $display("FAIL mult_ctl: got %b expected 1100", ca); end
        n_cmp++; if (o1 !== 32'd7 || o2 !== 32'hFFFF_FFFD) begin n_err++; $display("FAIL mult_ops: got %h/%h expected 00000007/fffffffd", o1, o2); end
        issue(FUNCT_MFLO, 32'h0, 32'h0, w, cf, ca, o1, o2);
        n_cmp++; if (cf !== MD_IDLE) begin n_err++; $display("FAIL mult_ctl_after_start: got %b expected 0000", cf); end
        n_cmp++; if (w !== 1) begin n_err++; $display("FAIL mult_mflo_wait: got %0d expected 1", w); end
        wait_resp(lat, crd);
        n_cmp++; if (crd !== MD_RD_LO) begin n_err++; $display("FAIL mflo_read_code: got %b expected 1001", crd); end
        n_cmp++; if (lat !== 2) begin n_err++; $display("FAIL mflo_latency: got %0d expected 2", lat); end
        n_cmp++; if (resp_data_o !== 32'hFFFF_FFEB) begin n_err++; $display("FAIL mult_lo: got %h expected ffffffeb", resp_data_o); end
        issue(FUNCT_MFHI, 32'h0, 32'h0, w, cf, ca, o1, o2);
        n_cmp++; if (w !== 0) begin n_err++; $display("FAIL mfhi_wait: got %0d expected 0", w); end
        wait_resp(lat, crd);
        n_cmp++; if (crd !== MD_RD_HI) begin n_err++; $display("FAIL mfhi_read_code: got %b expected 1000", crd); end
        n_cmp++; if (resp_data_o !== 32'hFFFF_FFFF || lat !== 2) begin n_err++; $display("FAIL mult_hi: got %h lat %0d expected ffffffff lat 2", resp_data_o, lat); end
        tick();
        n_cmp++; if (resp_valid_o !== 1'b0 || resp_data_o !== 32'hFFFF_FFFF) begin
            n_err++; $display("FAIL resp_pulse_hold: got rv=%b data=%h expected 0/ffffffff", resp_valid_o, resp_data_o);
        end
    endtask

    task automatic test_ignored_funct();
        int w;
        logic [3:0] cf, ca;
        logic [31:0] o1, o2;
        issue(6'b100000, 32'd1, 32'd2, w, cf, ca, o1, o2);
        n_cmp++; if (w !== 0 || ca !== MD_IDLE || o1 !== 32'h0) begin
            n_err++; $display("FAIL ignored_funct: got wait=%0d ctl=%b op1=%h expected 0/0000/0", w, ca, o1);
        end
        n_cmp++; if (req_ready_o !== 1'b1 || resp_valid_o !== 1'b0) begin
            n_err++; $display("FAIL ignored_funct_idle: got ready=%b rv=%b expected 1/0", req_ready_o, resp_valid_o);
        end
    endtask

    task automatic test_div(input logic [31:0] rs, input logic [31:0] rt,
                            input logic [31:0] exp_lo, input logic [31:0] exp_hi);
        int w, lat;
        logic [3:0] cf, ca, crd;
        logic [31:0] o1, o2;
        issue(FUNCT_DIV, rs, rt, w, cf, ca, o1, o2);
        n_cmp++; if (w !== 0 || ca !== MD_DIV || o1 !== rs || o2 !== rt) begin
            n_err++; $display("FAIL div_start: got wait=%0d ctl=%b ops=%h/%h expected 0/1101/%h/%h", w, ca, o1, o2, rs, rt);
        end
        issue(FUNCT_MFLO, 32'h0, 32'h0, w, cf, ca, o1, o2);
        n_cmp++; if (w !== 32) begin n_err++; $display("FAIL div_ready_low: got %0d expected 32", w); end
        wait_resp(lat, crd);
        n_cmp++; if (resp_data_o !== exp_lo || lat !== 2) begin n_err++; $display("FAIL div_lo: got %h lat %0d expected %h lat 2", resp_data_o, lat, exp_lo); end
        issue(FUNCT_MFHI, 32'h0, 32'h0, w, cf, ca, o1, o2);
        wait_resp(lat, crd);
        n_cmp++; if (resp_data_o !== exp_hi || w !== 0) begin n_err++; $display("FAIL div_hi: got %h wait %0d expected %h wait 0", resp_data_o, w, exp_hi); end
    endtask

    task automatic test_stall();
        int w, lat, lows;
        logic [3:0] cf, ca, crd;
        logic [31:0] o1, o2;
        md_stall_i = 1'b1;
        issue(FUNCT_DIV, 32'd5, 32'd2, w, cf, ca, o1, o2);
        lows = 0;
        for (int i = 1; i < 40; i++) begin
            #1;
            if (!req_ready_o) lows++;
            tick();
        end
        n_cmp++; if (lows !== 39) begin n_err++; $display("FAIL stall_hold: got %0d low cycles expected 39", lows); end
        md_stall_i = 1'b0;
        #1;
        n_cmp++; if (req_ready_o !== 1'b0) begin n_err++; $display("FAIL stall_drop_same_cycle: got ready=%b expected 0", req_ready_o); end
        tick();
        n_cmp++; if (req_ready_o !== 1'b1) begin n_err++; $display("FAIL stall_release: got ready=%b expected 1", req_ready_o); end
        issue(FUNCT_MFLO, 32'h0, 32'h0, w, cf, ca, o1, o2);
        wait_resp(lat, crd);
        n_cmp++; if (resp_data_o !== 32'd2) begin n_err++; $display("FAIL stall_div_lo: got %h expected 00000002", resp_data_o); end
    endtask

    task automatic test_async_reset();
        int w, lat;
        logic [3:0] cf, ca, crd;
        logic [31:0] o1, o2;
        issue(FUNCT_DIV, 32'd9, 32'd3, w, cf, ca, o1, o2);
        tick();
        tick();
        tick();
        #3;
        rst_ni = 1'b0;
        #1;
        n_cmp++; if (req_ready_o !== 1'b1 || md_ctl_o !== MD_IDLE) begin
            n_err++; $display("FAIL async_reset_comb: got ready=%b ctl=%b expected 1/0000", req_ready_o, md_ctl_o);
        end
        n_cmp++; if (resp_valid_o !== 1'b0 || resp_data_o !== 32'h0) begin
            n_err++; $display("FAIL async_reset_resp: got rv=%b data=%h expected 0/0", resp_valid_o, resp_data_o);
        end
        #1;
        rst_ni = 1'b1;
        tick();
        issue(FUNCT_MULT, 32'd6, 32'd7, w, cf, ca, o1, o2);
        n_cmp++; if (w !== 0 || ca !== MD_MULT) begin n_err++; $display("FAIL post_reset_mult: got wait=%0d ctl=%b expected 0/1100", w, ca); end
        issue(FUNCT_MFLO, 32'h0, 32'h0, w, cf, ca, o1, o2);
        wait_resp(lat, crd);
        n_cmp++; if (resp_data_o !== 32'd42 || w !== 1) begin n_err++; $display("FAIL post_reset_lo: got %h wait %0d expected 0000002a wait 1", resp_data_o, w); end
        issue(FUNCT_MFHI, 32'h0, 32'h0, w, cf, ca, o1, o2);
        wait_resp(lat, crd);
        n_cmp++; if (resp_data_o !== 32'h0 || lat !== 2) begin n_err++; $display("FAIL post_reset_hi: got %h lat %0d expected 0 lat 2", resp_data_o, lat); end
    endtask

    initial begin
        test_reset();
        test_mult();
        test_ignored_funct();
        test_div(32'd100, 32'd7, 32'd14, 32'd2);
        test_div(32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 32'hFFFF_FFFE);
        test_stall();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
